// File: rtl/serial_frame_pkg.sv
// Shared types and selector codes for the serial frame controller and its selector datapath.
// SERIAL_FRAME_HDR_EN adds the two header states to the state set.
package serial_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        THRESH,
`ifdef SERIAL_FRAME_HDR_EN
        HDR_H,
        HDR_L,
`endif
        DATA_H,
        DATA_L,
        STOP
    } state_t;

    localparam logic [2:0] SEL_ZERO  = 3'b000;
    localparam logic [2:0] SEL_ONE   = 3'b001;
    localparam logic [2:0] SEL_THRSH = 3'b010;
    localparam logic [2:0] SEL_H_B0  = 3'b011;
    localparam logic [2:0] SEL_L_B0  = 3'b100;
    localparam logic [2:0] SEL_H_B2  = 3'b101;
    localparam logic [2:0] SEL_L_B2  = 3'b110;

    // The line idles high, so IDLE and STOP share the constant-one code.
    function automatic logic [2:0] state_sel(input state_t s);
        case (s)
            START:   return SEL_ZERO;
            THRESH:  return SEL_THRSH;
`ifdef SERIAL_FRAME_HDR_EN
            HDR_H:   return SEL_H_B2;
            HDR_L:   return SEL_L_B2;
`endif
            DATA_H:  return SEL_H_B0;
            DATA_L:  return SEL_L_B0;
            default: return SEL_ONE;
        endcase
    endfunction

endpackage

// File: rtl/serial_frame_ctrl_bit_timer.sv
// Per-bit cycle counter: flags the last clock of each BIT_CYCLES-long bit period.
module bit_timer #(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic last
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign last = run && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear || last)
            cnt <= '0;
        else if (run)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/serial_frame_ctrl.sv
// Sequences one serial frame (start, thresh, [header], high bits, low bits, stop) through the selector.
// SERIAL_FRAME_HDR_EN inserts the regh_b2/regl_b2 header after THRESH.
module serial_frame_ctrl
    import serial_frame_pkg::*;
#(
    parameter int BIT_CYCLES = 4,
    parameter int DATA_W     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       ready,
    output logic       busy,
    output logic [2:0] muxsel,
    output logic       load,
    output logic       shift_h,
    output logic       shift_l,
    output logic       done
);

    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

    state_t        state, state_nxt;
    logic          last, state_chg;
    logic [IW-1:0] idx;

    assign state_chg = (state_nxt != state);

    bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state_chg),
        .run   (state != IDLE),
        .last  (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Bit index only advances inside a data state; every state change rewinds it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idx <= '0;
        else if (state_chg)
            idx <= '0;
        else if ((state == DATA_H || state == DATA_L) && last)
            idx <= idx + 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = START;
            START:   if (last)  state_nxt = THRESH;
`ifdef SERIAL_FRAME_HDR_EN
            THRESH:  if (last)  state_nxt = HDR_H;
            HDR_H:   if (last)  state_nxt = HDR_L;
            HDR_L:   if (last)  state_nxt = DATA_H;
`else
            THRESH:  if (last)  state_nxt = DATA_H;
`endif
            DATA_H:  if (last && idx == IDX_LAST) state_nxt = DATA_L;
            DATA_L:  if (last && idx == IDX_LAST) state_nxt = STOP;
            STOP:    if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ready   = (state == IDLE);
    assign busy    = !ready;
    assign load    = start && ready;
    assign shift_h = (state == DATA_H) && last;
    assign shift_l = (state == DATA_L) && last;
    assign done    = (state == STOP) && last;
    assign muxsel  = state_sel(state);

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Scoreboard bench: two controller instances (4/4 and 1/2), per-cycle expected output vectors queued on start.
module tb_serial_frame_ctrl;

    localparam int BC0 = 4, DW0 = 4, BC1 = 1, DW1 = 2;
`ifdef SERIAL_FRAME_HDR_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    // {ready, busy, muxsel[2:0], load, shift_h, shift_l, done}
    typedef logic [8:0] vec_t;
    localparam vec_t IDLE_V = 9'b1_0_001_0_000;

    logic clk = 1'b0, rst_n = 1'b0, start0 = 1'b0, start1 = 1'b0;
    logic ready0, busy0, load0, sh0, sl0, dn0;
    logic ready1, busy1, load1, sh1, sl1, dn1;
    logic [2:0] mux0, mux1;

    vec_t q0[$], q1[$];
    vec_t e0, e1;
    int errs = 0, checks = 0;
    int done_cnt0 = 0, done_cnt1 = 0, frames1 = 0;

    always #5 clk = ~clk;

    serial_frame_ctrl #(.BIT_CYCLES(BC0), .DATA_W(DW0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .ready(ready0), .busy(busy0),
        .muxsel(mux0), .load(load0), .shift_h(sh0), .shift_l(sl0), .done(dn0)
    );

    serial_frame_ctrl #(.BIT_CYCLES(BC1), .DATA_W(DW1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .ready(ready1), .busy(busy1),
        .muxsel(mux1), .load(load1), .shift_h(sh1), .shift_l(sl1), .done(dn1)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void push_v(input int id, input vec_t v);
        if (id == 0) q0.push_back(v);
        else         q1.push_back(v);
    endfunction

    // kind: 0 no strobe, 1 shift_h, 2 shift_l, 3 done -- each on the last cycle of the bit
    function automatic void push_bit(input int id, input int bc, input logic [2:0] sel, input int kind);
        for (int c = 0; c < bc; c++) begin
            logic lst;
            lst = (c == bc - 1);
            push_v(id, {1'b0, 1'b1, sel, 1'b0, lst && kind == 1, lst && kind == 2, lst && kind == 3});
        end
    endfunction

    function automatic void push_frame(input int id, input int bc, input int dw);
        push_bit(id, bc, 3'b000, 0);
        push_bit(id, bc, 3'b010, 0);
        if (HDR) begin
            push_bit(id, bc, 3'b101, 0);
            push_bit(id, bc, 3'b110, 0);
        end
        for (int i = 0; i < dw; i++) push_bit(id, bc, 3'b011, 1);
        for (int i = 0; i < dw; i++) push_bit(id, bc, 3'b100, 2);
        push_bit(id, bc, 3'b001, 3);
    endfunction

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0.delete();
        end else begin
            if (q0.size() == 0) begin
                e0 = IDLE_V;
                if (start0) begin
                    e0[3] = 1'b1;
                    push_frame(0, BC0, DW0);
                end
            end else begin
                e0 = q0.pop_front();
            end
            chk("dut0_cycle", 32'({ready0, busy0, mux0, load0, sh0, sl0, dn0}), 32'(e0));
            if (dn0) done_cnt0++;
        end
    end

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1.delete();
        end else begin
            if (q1.size() == 0) begin
                e1 = IDLE_V;
                if (start1) begin
                    e1[3] = 1'b1;
                    push_frame(1, BC1, DW1);
                    frames1++;
                end
            end else begin
                e1 = q1.pop_front();
            end
            chk("dut1_cycle", 32'({ready1, busy1, mux1, load1, sh1, sl1, dn1}), 32'(e1));
            if (dn1) done_cnt1++;
        end
    end

    task automatic wait_drain(input int id);
        int left;
        left = (id == 0) ? q0.size() : q1.size();
        for (int i = 0; i < 500 && left != 0; i++) begin
            @(posedge clk);
            left = (id == 0) ? q0.size() : q1.size();
        end
        chk("drain_timeout", 32'(left), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start0();
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vec0", 32'({ready0, busy0, mux0, sh0, sl0, dn0}), 32'(8'b1_0_001_000));
        chk("rst_load0", 32'(load0), 32'd0);
        chk("rst_vec1", 32'({ready1, busy1, mux1, sh1, sl1, dn1}), 32'(8'b1_0_001_000));
        rst_n = 1'b1;
        repeat (20) @(posedge clk);

        // full frame with an ignored start at T+20
        pulse_start0();
        repeat (19) @(posedge clk);
        #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        wait_drain(0);
        chk("dut0_done_after_frame1", 32'(done_cnt0), 32'd1);

        // async reset in DATA_H at T+22
        pulse_start0();
        repeat (21) @(posedge clk);
        #1 chk("pre_rst_busy", 32'({busy0, mux0}), 32'({1'b1, 3'b011}));
        rst_n = 1'b0;
        #1;
        chk("async_rst_mux", 32'(mux0), 32'd1);
        chk("async_rst_busy", 32'(busy0), 32'd0);
        chk("async_rst_ready", 32'(ready0), 32'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        pulse_start0();
        wait_drain(0);
        chk("dut0_done_total", 32'(done_cnt0), 32'd2);

        // continuous start on the single-cycle-bit instance
        @(posedge clk); #1 start1 = 1'b1;
        repeat (30) @(posedge clk);
        #1 start1 = 1'b0;
        wait_drain(1);
        chk("dut1_frames", 32'(frames1), HDR ? 32'd3 : 32'd4);
        chk("dut1_done_cnt", 32'(done_cnt1), 32'(frames1));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
